result_ascii_tx: RTL and testbench
==================================

RESULT_ASCII_TX -- requirements
Module: result_ascii_tx

Interface
REQ-001 The block SHALL have parameter TERM_CHAR, default 8'h0A: byte sent after the last digit.
REQ-002 The block SHALL have parameter EMIT_TERM, default 1: 1 sends TERM_CHAR, 0 omits it.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port data_in  input  64  unsigned result from the day-3 accumulator output_data.
REQ-006 The block SHALL have port data_in_valid  input  1  level-valid from the accumulator output_data_valid; may be held high indefinitely.
REQ-007 The block SHALL have port tx_byte  output  8  ASCII character offered downstream.
REQ-008 The block SHALL have port tx_valid  output  1  tx_byte is valid.
REQ-009 The block SHALL have port tx_ready  input  1  downstream accepts tx_byte this cycle.
REQ-010 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 The block SHALL have port done  output  1  one-cycle pulse after the final byte is accepted.

Function
REQ-012 The block SHALL implement states IDLE, CONVERT, SKIP, EMIT, TERM, FIN.
REQ-013 In IDLE, a start SHALL occur on an edge where data_in_valid=1 and the registered previous data_in_valid=0; data_in is captured on that edge (edge N) and the state becomes CONVERT.
REQ-014 Start events outside IDLE SHALL be ignored, not queued; valid held high across completion SHALL NOT retrigger.
REQ-015 CONVERT SHALL perform binary-to-BCD double-dabble, one bit per edge, over exactly 64 edges (N+1..N+64), producing 20 BCD digits; at edge N+64 the state becomes SKIP with digit index 19.
REQ-016 In SKIP, on each edge: if digit[index]!=0 or index==0 the state becomes EMIT; else index decrements; SKIP SHALL last L+1 edges, where L = number of leading zero digits (0..19).
REQ-017 In EMIT, tx_valid SHALL be 1 and tx_byte SHALL equal 8'h30 + digit[index]; first tx_valid is high after edge N+65+L.
REQ-018 On tx_valid && tx_ready in EMIT: if index==0, go to TERM when EMIT_TERM=1, else to FIN; otherwise index decrements and EMIT continues (back-to-back bytes, no bubble).
REQ-019 While tx_valid=1 and tx_ready=0, tx_byte SHALL remain stable and tx_valid SHALL stay high.
REQ-020 In TERM, tx_valid=1 and tx_byte=TERM_CHAR; on acceptance, the state becomes FIN.
REQ-021 FIN SHALL assert done for exactly one cycle and return to IDLE.
REQ-022 Value 0 SHALL emit the single digit "0" (index reaches 0).
REQ-023 The full 64-bit range SHALL be supported; 2^64-1 emits 20 digits with no overflow.
REQ-024 tx_valid SHALL be 0 in IDLE, CONVERT, SKIP and FIN.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, tx_valid=0, tx_byte=0, busy=0, done=0, previous-valid register=0, digits=0, index=0.
REQ-026 Reset mid-operation SHALL abort the transfer without emitting further bytes; after release, data_in_valid already high SHALL trigger a new start.

Structure
REQ-027 The state enum, ASCII_ZERO (8'h30) and BCD_DIGITS (20) SHALL live in shared package aoc_pkg.
REQ-028 The double-dabble engine SHALL be one sub-module, bin2bcd_seq (start/busy/done, 64-bit in, 80-bit BCD out), instantiated once.

Verification
REQ-029 Bench SHALL cover: data_in=0, tx_ready=1 -> bytes 0x30,0x0A; done one cycle after the 0x0A handshake.
REQ-030 Bench SHALL cover: data_in=1234, tx_ready=1 -> 0x31,0x32,0x33,0x34,0x0A; first tx_valid after edge N+65+16.
REQ-031 Bench SHALL cover: data_in=18446744073709551615 -> 20 digits "18446744073709551615" then 0x0A; L=0.
REQ-032 Bench SHALL cover: data_in=907, tx_ready random toggling -> 0x39,0x30,0x37,0x0A in order; tx_byte stable while stalled.
REQ-033 Bench SHALL cover: data_in_valid held high for 500 cycles -> exactly one transfer, one done pulse.
REQ-034 Bench SHALL cover: rst_n low during the 2nd digit of 1234 -> tx_valid=0 immediately; after release with valid high, full 1234 transfer restarts.

Source files
------------

// File: rtl/aoc_pkg.sv
// Shared definitions for the result-to-ASCII transmitter and its BCD engine.
//   state_e        : transmitter FSM states
//   ASCII_ZERO     : code of character '0'
//   BCD_DIGITS     : decimal digits needed for a 64-bit unsigned value
//   digit_to_ascii : map one BCD digit to its ASCII character
package aoc_pkg;

  localparam int unsigned BIN_WIDTH  = 64;
  localparam int unsigned BCD_DIGITS = 20;
  localparam logic [7:0]  ASCII_ZERO = 8'h30;

  typedef enum logic [2:0] {
    StIdle,
    StConvert,
    StSkip,
    StEmit,
    StTerm,
    StFin
  } state_e;

  function automatic logic [7:0] digit_to_ascii(input logic [3:0] digit);
    return ASCII_ZERO + {4'b0000, digit};
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one input bit per clock, 64 clocks per conversion.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   start_i : load bin_i and begin converting (ignored while busy)
//   bin_i   : unsigned binary value
//   busy_o  : conversion in progress
//   done_o  : high during the cycle whose rising edge performs the final step;
//             bcd_o holds the finished result right after that edge
//   bcd_o   : 20 packed BCD digits, digit 0 in bits [3:0]
module bin2bcd_seq
  import aoc_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [BIN_WIDTH-1:0]    bin_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [4*BCD_DIGITS-1:0] bcd_o
);

  logic [BIN_WIDTH-1:0]    bin_q, bin_d;
  logic [4*BCD_DIGITS-1:0] bcd_q, bcd_d, bcd_adj;
  logic [5:0]              cnt_q, cnt_d;
  logic                    busy_q, busy_d;

  always_comb begin
    // Add-3 correction on every digit that would overflow once doubled.
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(BCD_DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end

    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (busy_q) begin
      bin_d = bin_q << 1;
      bcd_d = (bcd_adj << 1) | {{(4*BCD_DIGITS-1){1'b0}}, bin_q[BIN_WIDTH-1]};
      cnt_d = cnt_q + 6'd1;
      if (cnt_q == 6'd63) begin
        busy_d = 1'b0;
      end
    end else if (start_i) begin
      bin_d  = bin_i;
      bcd_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == 6'd63);
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/result_ascii_tx.sv
// Sends a 64-bit unsigned result as decimal ASCII over a valid/ready byte stream,
// leading zeros suppressed, optionally followed by a terminator character.
//   clk, rst_n             : clock, asynchronous active-low reset
//   data_in, data_in_valid : result and its level-valid; a rising valid starts a transfer
//   tx_byte, tx_valid      : character offered downstream
//   tx_ready               : downstream accepts tx_byte this cycle
//   busy                   : transfer in progress (any state but idle)
//   done                   : one-cycle pulse after the final byte is accepted
module result_ascii_tx
  import aoc_pkg::*;
#(
  parameter logic [7:0] TERM_CHAR = 8'h0A,
  parameter bit         EMIT_TERM = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BIN_WIDTH-1:0] data_in,
  input  logic                 data_in_valid,
  output logic [7:0]           tx_byte,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic                 done
);

  state_e     state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic       valid_prev_q;

  logic                           start;
  logic                           bcd_busy;
  logic                           bcd_done;
  logic [BCD_DIGITS-1:0][3:0]     digits;
  logic [3:0]                     cur_digit;

  // Only a rising edge of valid starts a transfer, so a held-high valid fires once.
  assign start     = (state_q == StIdle) && data_in_valid && !valid_prev_q;
  assign cur_digit = digits[idx_q];

  bin2bcd_seq u_bin2bcd (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start),
    .bin_i   (data_in),
    .busy_o  (bcd_busy),
    .done_o  (bcd_done),
    .bcd_o   (digits)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tx_valid = 1'b0;
    tx_byte  = 8'h00;
    done     = 1'b0;
    busy     = (state_q != StIdle);
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StConvert;
        end
      end
      StConvert: begin
        if (bcd_done) begin
          state_d = StSkip;
          idx_d   = 5'(BCD_DIGITS - 1);
        end else if (!bcd_busy) begin
          // Engine idle without finishing: recover rather than wait forever.
          state_d = StIdle;
        end
      end
      StSkip: begin
        // Digit 0 is always sent so that a zero value still produces "0".
        if (cur_digit != 4'd0 || idx_q == 5'd0) begin
          state_d = StEmit;
        end else begin
          idx_d = idx_q - 5'd1;
        end
      end
      StEmit: begin
        tx_valid = 1'b1;
        tx_byte  = digit_to_ascii(cur_digit);
        if (tx_ready) begin
          if (idx_q == 5'd0) begin
            state_d = EMIT_TERM ? StTerm : StFin;
          end else begin
            idx_d = idx_q - 5'd1;
          end
        end
      end
      StTerm: begin
        tx_valid = 1'b1;
        tx_byte  = TERM_CHAR;
        if (tx_ready) begin
          state_d = StFin;
        end
      end
      StFin: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      valid_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      valid_prev_q <= data_in_valid;
    end
  end

endmodule

// File: tb/tb_result_ascii_tx.sv
module tb_result_ascii_tx;

  logic        clk;
  logic        rst_n;
  logic [63:0] data_in;
  logic        data_in_valid;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] got[$];

  result_ascii_tx dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .tx_byte       (tx_byte),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (time %0t, required finish)", $time);
    $fatal(1);
  end

  function automatic logic [7:0] got_at(input int i);
    return (i < got.size()) ? got[i] : 8'hxx;
  endfunction

  // Runs one transfer starting at the current negedge; collects accepted bytes into got.
  // lat: edges after the start edge until tx_valid is first seen.
  task automatic xfer(input logic [63:0] v, input bit stall, input bit hold,
                      output int lat, output int done_cnt, output int done_gap,
                      output int n_stall, output bit stall_ok, output bit timed_out);
    int k, hs_k, done_k, post;
    bit prev_stall, rdy;
    logic [7:0] prev_byte;
    got.delete();
    lat = -1; done_cnt = 0; n_stall = 0; stall_ok = 1'b1; timed_out = 1'b0;
    hs_k = -1; done_k = -1; post = 0; prev_stall = 1'b0; prev_byte = 8'h00;
    data_in = v;
    data_in_valid = 1'b1;
    @(negedge clk);
    k = 0;
    while (post < 3) begin
      if (k >= 3000) begin
        timed_out = 1'b1;
        break;
      end
      if (tx_valid === 1'b1 && lat < 0) lat = k;
      if (prev_stall) begin
        n_stall++;
        if (tx_valid !== 1'b1 || tx_byte !== prev_byte) stall_ok = 1'b0;
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (done_k >= 0) post++;
      rdy = stall ? (k % 3 == 2) : 1'b1;
      tx_ready = rdy;
      if (tx_valid === 1'b1 && rdy) begin
        got.push_back(tx_byte);
        hs_k = k;
      end
      prev_stall = (tx_valid === 1'b1) && !rdy;
      prev_byte  = tx_byte;
      @(negedge clk);
      k++;
    end
    done_gap = (done_k >= 0 && hs_k >= 0) ? done_k - hs_k : -1;
    if (!hold) begin
      data_in_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; data_in = '0; data_in_valid = 1'b0; tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_ctrl: valid/busy/done=%b%b%b, required 000", tx_valid, busy, done);
    else n_pass++;
    n_checks++;
    if (tx_byte !== 8'h00) $display("FAIL reset_byte: got %h, required 00", tx_byte);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || tx_valid !== 1'b0)
      $display("FAIL reset_idle: busy=%b valid=%b after release, required 0 0", busy, tx_valid);
    else n_pass++;
  endtask

  task automatic test_value(input string nm, input logic [63:0] v, input string exp,
                            input int exp_lat, input bit stall);
    int lat, dc, dg, ns;
    bit sok, to;
    xfer(v, stall, 1'b0, lat, dc, dg, ns, sok, to);
    n_checks++;
    if (to) $display("FAIL %s_timeout: no done within bound, required done", nm);
    else n_pass++;
    n_checks++;
    if (lat != exp_lat) $display("FAIL %s_latency: got %0d, required %0d", nm, lat, exp_lat);
    else n_pass++;
    n_checks++;
    if (got.size() != exp.len())
      $display("FAIL %s_count: got %0d bytes, required %0d", nm, got.size(), exp.len());
    else n_pass++;
    for (int i = 0; i < exp.len(); i++) begin
      n_checks++;
      if (got_at(i) !== exp[i])
        $display("FAIL %s_byte%0d: got %h, required %h", nm, i, got_at(i), exp[i]);
      else n_pass++;
    end
    n_checks++;
    if (dc != 1 || dg != 1)
      $display("FAIL %s_done: pulses %0d gap %0d, required 1 pulse gap 1", nm, dc, dg);
    else n_pass++;
    if (stall) begin
      n_checks++;
      if (!sok || ns == 0)
        $display("FAIL %s_stall: stable=%0d stalls=%0d, required stable=1 stalls>0", nm, sok, ns);
      else n_pass++;
    end
  endtask

  task automatic test_hold_valid();
    int lat, dc, dg, ns, extra;
    bit sok, to;
    xfer(64'd5, 1'b0, 1'b1, lat, dc, dg, ns, sok, to);
    n_checks++;
    if (to || dc != 1 || got.size() != 2 || got_at(0) !== 8'h35 || got_at(1) !== 8'h0A)
      $display("FAIL hold_first: done %0d bytes %0d b0 %h, required 1 2 35", dc, got.size(),
               got_at(0));
    else n_pass++;
    extra = 0;
    for (int i = 0; i < 500; i++) begin
      if (busy !== 1'b0 || done !== 1'b0 || tx_valid !== 1'b0) extra++;
      @(negedge clk);
    end
    n_checks++;
    if (extra != 0) $display("FAIL hold_retrigger: %0d active cycles, required 0", extra);
    else n_pass++;
    data_in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat, dc, dg, ns, w;
    bit sok, to;
    string exp;
    exp = "1234\n";
    data_in = 64'd1234; data_in_valid = 1'b1; tx_ready = 1'b0;
    w = 0;
    while (tx_valid !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    n_checks++;
    if (tx_valid !== 1'b1 || tx_byte !== 8'h31)
      $display("FAIL rmid_first: valid %b byte %h, required 1 31", tx_valid, tx_byte);
    else n_pass++;
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    n_checks++;
    if (tx_valid !== 1'b1 || tx_byte !== 8'h32)
      $display("FAIL rmid_second: valid %b byte %h, required 1 32", tx_valid, tx_byte);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || tx_byte !== 8'h00 || done !== 1'b0)
      $display("FAIL rmid_abort: valid %b busy %b byte %h done %b, required 0 0 00 0",
               tx_valid, busy, tx_byte, done);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    xfer(64'd1234, 1'b0, 1'b0, lat, dc, dg, ns, sok, to);
    n_checks++;
    if (to || lat != 81 || dc != 1)
      $display("FAIL rmid_restart: timeout %0d lat %0d done %0d, required 0 81 1", to, lat, dc);
    else n_pass++;
    n_checks++;
    if (got.size() != exp.len())
      $display("FAIL rmid_count: got %0d bytes, required %0d", got.size(), exp.len());
    else n_pass++;
    for (int i = 0; i < exp.len(); i++) begin
      n_checks++;
      if (got_at(i) !== exp[i])
        $display("FAIL rmid_byte%0d: got %h, required %h", i, got_at(i), exp[i]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_value("zero", 64'd0, "0\n", 84, 1'b0);
    test_value("v1234", 64'd1234, "1234\n", 81, 1'b0);
    test_value("max", 64'hFFFF_FFFF_FFFF_FFFF, "18446744073709551615\n", 65, 1'b0);
    test_value("stall907", 64'd907, "907\n", 82, 1'b1);
    test_hold_valid();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
